// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS        = 8;
  localparam int BIT_IDX_W        = 4;
  localparam int CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Serial line plus the shift-register write controls of the receive front end.
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic                 i_rx;
  logic                 shift_rst;
  logic                 catch_bit;
  logic [BIT_IDX_W-1:0] catch_bit_cnt;
  logic                 o_rx_done;
  logic                 o_frame_err;

  modport master (
    input  i_rx,
    output shift_rst,
    output catch_bit,
    output catch_bit_cnt,
    output o_rx_done,
    output o_frame_err
  );

  modport slave (
    output i_rx,
    input  shift_rst,
    input  catch_bit,
    input  catch_bit_cnt,
    input  o_rx_done,
    input  o_frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line with a history flop for falling-edge detection.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async,
  output logic rx_sync,
  output logic rx_fall
);

  logic rx_s1_q, rx_s1_d;
  logic rx_s2_q, rx_s2_d;
  logic rx_s3_q, rx_s3_d;

  always_comb begin
    rx_s1_d = rx_async;
    rx_s2_d = rx_s1_q;
    rx_s3_d = rx_s2_q;
  end

  // Reset to the idle-high level so leaving reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      rx_s3_q <= rx_s3_d;
    end
  end

  assign rx_sync = rx_s2_q;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive bit recovery: start detection, 3-sample majority vote per bit, shift-register write controls.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_sampler_if.master rx_if
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic rx_s2;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_async (rx_if.i_rx),
    .rx_sync  (rx_s2),
    .rx_fall  (rx_fall)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic                 shift_rst_q, shift_rst_d;
  logic                 catch_bit_q, catch_bit_d;
  logic [BIT_IDX_W-1:0] catch_cnt_q, catch_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic cnt_last;
  logic vote_cyc;
  logic vote;

  always_comb begin
    cnt_last = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    vote_cyc = (clk_cnt_q == CNT_W'(MID + 1));
    // Third sample is the live rx_s2 in the vote cycle itself
    vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2) | (samp_q[1] & rx_s2);
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shift_rst_d = 1'b0;
    catch_bit_d = catch_bit_q;
    catch_cnt_d = catch_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Register is already cleared; park the write controls on a harmless value
    if (shift_rst_q) begin
      catch_bit_d = 1'b0;
      catch_cnt_d = '0;
    end

    if (state_q != IDLE) begin
      clk_cnt_d = cnt_last ? '0 : clk_cnt_q + 1'b1;
      if (clk_cnt_q == CNT_W'(MID - 1)) samp_d[0] = rx_s2;
      if (clk_cnt_q == CNT_W'(MID))     samp_d[1] = rx_s2;
    end

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (vote_cyc) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            shift_rst_d = 1'b1;
            bit_idx_d   = '0;
          end
        end else if (cnt_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_cyc) begin
          catch_bit_d = vote;
          catch_cnt_d = bit_idx_q;
        end
        if (cnt_last) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) state_d = STOP;
          else                                        bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        // Back to IDLE at the centre so a start edge in the late stop bit is caught
        if (vote_cyc) begin
          done_d  = 1'b1;
          err_d   = ~vote;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_rst_q <= 1'b0;
      catch_bit_q <= 1'b0;
      catch_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_rst_q <= shift_rst_d;
      catch_bit_q <= catch_bit_d;
      catch_cnt_q <= catch_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    samp_q <= samp_d;
  end

  assign rx_if.shift_rst     = shift_rst_q;
  assign rx_if.catch_bit     = catch_bit_q;
  assign rx_if.catch_bit_cnt = catch_cnt_q;
  assign rx_if.o_rx_done     = done_q;
  assign rx_if.o_frame_err   = err_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frames plus random traffic against a frame-timing model.
module tb_uart_rx_sampler;

  localparam int N   = 16;
  localparam int MID = N / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if.master)
  );

  typedef struct packed {
    logic       srst;
    logic       cb;
    logic [3:0] cnt;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } frm_t;

  bit   line_q[$];
  bit   rstn_q[$];
  frm_t exp_q[$];
  obs_t ev[];
  bit   s1[], s2[], s3[];

  int n_chk = 0;
  int n_fail = 0;

  // Downstream 8-bit receive register, written every cycle
  logic [7:0] ds_byte;
  always @(posedge clk) begin
    if (rx_if.shift_rst === 1'b1) ds_byte <= 8'h00;
    else if (rx_if.catch_bit_cnt < 4'd8) ds_byte[rx_if.catch_bit_cnt[2:0]] <= rx_if.catch_bit;
  end

  task automatic push(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      line_q.push_back(v);
      rstn_q.push_back(1'b1);
    end
  endtask

  // Frame on the line; spike_at >= 0 inverts that one line cycle
  task automatic frame(input logic [7:0] d, input bit stop, input int stop_len, input int spike_at);
    int base;
    base = line_q.size();
    push(1'b0, N);
    for (int b = 0; b < 8; b++) push(d[b], N);
    push(stop, stop_len);
    if (spike_at >= 0) line_q[base + spike_at] = ~line_q[base + spike_at];
  endtask

  function automatic frm_t mk(input logic [7:0] d, input logic e);
    frm_t f;
    f.data = d;
    f.err  = e;
    return f;
  endfunction

  int   l_a5, dir_end, T;
  int   first_done, first_srst, dir_srst;
  logic [7:0] got_b[$];
  bit   got_e[$];
  obs_t obs, nx, cur;
  frm_t ef;
  logic [7:0] lit_b [6];
  bit         lit_e [6];

  initial begin
    int base, active, c0, off, bitn, ph, kind;
    bit v;
    rx_if.i_rx = 1'b1;
    first_done = -1;
    first_srst = -1;
    dir_srst   = 0;

    // ---------------- directed stimulus ----------------
    push(1'b1, 4);
    for (int i = 0; i < 4; i++) rstn_q[i] = 1'b0;
    push(1'b1, 10);
    l_a5 = line_q.size();
    frame(8'hA5, 1'b1, N, -1); exp_q.push_back(mk(8'hA5, 1'b0)); push(1'b1, 20);
    push(1'b0, 4); push(1'b1, 40);
    frame(8'h3C, 1'b0, N, -1); exp_q.push_back(mk(8'h3C, 1'b1)); push(1'b1, 20);
    frame(8'hFF, 1'b1, N, 4*N + MID + 1); exp_q.push_back(mk(8'hFF, 1'b0)); push(1'b1, 20);
    frame(8'h55, 1'b1, MID + 4, -1); exp_q.push_back(mk(8'h55, 1'b0));
    frame(8'h81, 1'b1, N, -1); exp_q.push_back(mk(8'h81, 1'b0)); push(1'b1, 20);
    base = line_q.size();
    frame(8'hF0, 1'b1, N, -1);
    rstn_q[base + 5*N + 4] = 1'b0;
    push(1'b1, 20);
    frame(8'h0F, 1'b1, N, -1); exp_q.push_back(mk(8'h0F, 1'b0)); push(1'b1, 20);
    dir_end = line_q.size();

    // ---------------- random stimulus ----------------
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        push(1'b0, $urandom_range(1, MID - 2));
        push(1'b1, N + MID + $urandom_range(0, 10));
      end else begin
        logic [7:0] d;
        bit st;
        int sp;
        d  = 8'($urandom_range(0, 255));
        st = ($urandom_range(0, 5) != 0);
        sp = ($urandom_range(0, 1) != 0) ? $urandom_range(N, 9*N - 1) : -1;
        frame(d, st, N, sp);
        exp_q.push_back(mk(d, ~st));
        push(1'b1, $urandom_range(2, 30));
      end
    end
    push(1'b1, 30);
    T = line_q.size();

    // ---------------- frame-timing reference model ----------------
    s1 = new[T]; s2 = new[T]; s3 = new[T]; ev = new[T];
    for (int k = 0; k < T; k++) begin
      s1[k] = rstn_q[k] ? line_q[k] : 1'b1;
      s2[k] = rstn_q[k] ? ((k > 0) ? s1[k-1] : 1'b1) : 1'b1;
      s3[k] = rstn_q[k] ? ((k > 0) ? s2[k-1] : 1'b1) : 1'b1;
    end
    active = 0; c0 = 0; nx = '0;
    for (int k = 0; k < T; k++) begin
      if (!rstn_q[k]) begin
        cur = '0;
        active = 0;
      end else begin
        cur = nx;
      end
      ev[k] = cur;
      nx = cur;
      nx.srst = 1'b0; nx.done = 1'b0; nx.err = 1'b0;
      if (cur.srst) begin nx.cb = 1'b0; nx.cnt = 4'd0; end
      if (active == 0) begin
        if (s3[k] && !s2[k]) begin active = 1; c0 = k; end
      end else begin
        off  = k - c0 - 1;
        bitn = off / N;
        ph   = off % N;
        if (ph == MID + 1) begin
          v = (int'(s2[k-2]) + int'(s2[k-1]) + int'(s2[k])) >= 2;
          if (bitn == 0) begin
            if (v) active = 0;
            else   nx.srst = 1'b1;
          end else if (bitn <= 8) begin
            nx.cb  = v;
            nx.cnt = 4'(bitn - 1);
          end else begin
            nx.done = 1'b1;
            nx.err  = ~v;
            active  = 0;
          end
        end
      end
    end

    // ---------------- drive and compare every cycle ----------------
    for (int k = 0; k < T; k++) begin
      rx_if.i_rx = line_q[k];
      rst_n      = rstn_q[k];
      @(posedge clk);
      #1;
      obs = {rx_if.shift_rst, rx_if.catch_bit, rx_if.catch_bit_cnt, rx_if.o_rx_done, rx_if.o_frame_err};
      n_chk++;
      if (obs !== ev[k]) begin
        n_fail++;
        $display("FAIL cycle_outputs cycle=%0d got srst=%b cb=%b cnt=%0d done=%b err=%b want srst=%b cb=%b cnt=%0d done=%b err=%b",
                 k, obs.srst, obs.cb, obs.cnt, obs.done, obs.err,
                 ev[k].srst, ev[k].cb, ev[k].cnt, ev[k].done, ev[k].err);
      end
      if (!rstn_q[k]) begin
        n_chk++;
        if (obs !== '0) begin
          n_fail++;
          $display("FAIL reset_state cycle=%0d got %b want 00000000", k, obs);
        end
      end
      if (rx_if.shift_rst === 1'b1) begin
        if (first_srst < 0) first_srst = k;
        if (k < dir_end) dir_srst++;
      end
      if (rx_if.o_rx_done === 1'b1) begin
        if (first_done < 0) first_done = k;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done cycle=%0d got byte=%h want no frame", k, ds_byte);
        end else begin
          ef = exp_q.pop_front();
          if (ds_byte !== ef.data || rx_if.o_frame_err !== ef.err) begin
            n_fail++;
            $display("FAIL frame_byte cycle=%0d got byte=%h err=%b want byte=%h err=%b",
                     k, ds_byte, rx_if.o_frame_err, ef.data, ef.err);
          end
        end
        if (k < dir_end) begin
          got_b.push_back(ds_byte);
          got_e.push_back(rx_if.o_frame_err);
        end
      end
    end

    // ---------------- hand-computed expectations ----------------
    lit_b = '{8'hA5, 8'h3C, 8'hFF, 8'h55, 8'h81, 8'h0F};
    lit_e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_chk++;
    if (got_b.size() != 6) begin
      n_fail++;
      $display("FAIL directed_done_count got %0d want 6", got_b.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < got_b.size()) begin
        n_chk++;
        if (got_b[i] !== lit_b[i] || got_e[i] !== lit_e[i]) begin
          n_fail++;
          $display("FAIL directed_frame_%0d got byte=%h err=%b want byte=%h err=%b",
                   i, got_b[i], got_e[i], lit_b[i], lit_e[i]);
        end
      end
    end
    n_chk++;
    if (dir_srst != 7) begin
      n_fail++;
      $display("FAIL directed_shift_rst_count got %0d want 7", dir_srst);
    end
    n_chk++;
    if (first_srst != l_a5 + 12) begin
      n_fail++;
      $display("FAIL first_shift_rst_cycle got %0d want %0d", first_srst, l_a5 + 12);
    end
    n_chk++;
    if (first_done != l_a5 + 156) begin
      n_fail++;
      $display("FAIL first_done_cycle got %0d want %0d", first_done, l_a5 + 156);
    end
    n_chk++;
    if (ev[l_a5 + 156].done !== 1'b1 || ev[l_a5 + 12].srst !== 1'b1) begin
      n_fail++;
      $display("FAIL model_timing_pin got done=%b srst=%b want done=1 srst=1",
               ev[l_a5 + 156].done, ev[l_a5 + 12].srst);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frames_outstanding got %0d want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
